// File: rtl/dmem_bridge_if.sv
// Signal bundle between the core data port, dmem_bridge and the external bus.
// The bridge uses the master modport; the core/bus side uses slave.
interface dmem_bridge_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        ram_stall;
    logic        ram_cs;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        input  mem_ren, mem_wen, mem_addr, mem_dout, bus_ack, bus_rdata,
        output mem_din, ram_stall, ram_cs, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );

    modport slave (
        output mem_ren, mem_wen, mem_addr, mem_dout, bus_ack, bus_rdata,
        input  mem_din, ram_stall, ram_cs, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );
endinterface

// File: rtl/dmem_bridge.sv
// Core data-memory port to single-outstanding bus bridge (IDLE -> BUSY -> DONE).
// Optional BUSY-state timeout is enabled by defining DMEM_TIMEOUT_EN.
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic           clk,
    input logic           rst,
    dmem_bridge_if.master dif
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic        req_in;
    logic        ack_hit;
    logic        timeout_hit;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] din_q;

    assign req_in  = dif.mem_ren | dif.mem_wen;
    assign ack_hit = (state == BUSY) && dif.bus_ack;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // Fires on the BUSY cycle whose missing ack would bring the count to TIMEOUT_CYCLES.
    assign timeout_hit = (state == BUSY) && !dif.bus_ack &&
                         (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && req_in)
                wait_cnt <= '0;
            else if (state == BUSY && !dif.bus_ack)
                wait_cnt <= wait_cnt + 1'b1;
            err_q <= timeout_hit;
        end
    end

    assign dif.bus_err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES[0];
    assign timeout_hit    = 1'b0;
    assign dif.bus_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_in) state_nxt = BUSY;
            BUSY:    if (ack_hit || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request is captured once at IDLE; later changes on the core side (flush) cannot alter it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            din_q   <= '0;
        end else begin
            if (state == IDLE && req_in) begin
                we_q    <= dif.mem_wen;
                addr_q  <= dif.mem_addr;
                wdata_q <= dif.mem_dout;
            end
            if (ack_hit && !we_q)
                din_q <= dif.bus_rdata;
            else if (timeout_hit && !we_q)
                din_q <= '0;
        end
    end

    assign dif.bus_req   = (state == BUSY);
    assign dif.ram_cs    = (state == BUSY);
    assign dif.ram_stall = (state == BUSY) || ((state == IDLE) && req_in);
    assign dif.bus_we    = we_q;
    assign dif.bus_addr  = addr_q;
    assign dif.bus_wdata = wdata_q;
    assign dif.mem_din   = din_q;
endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed vector table, corner sequences
// and randomized transactions against a transaction-level reference model.
module tb_dmem_bridge;
    localparam int unsigned TB_TIMEOUT = 4;
`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned MAXW = TB_TIMEOUT - 1;
`else
    localparam int unsigned MAXW = 7;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   episodes = 0;
    logic prev_req = 1'b0;
    int   m_txns = 0;
    logic [31:0] m_din;

    dmem_bridge_if dif ();

    dmem_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk = ~clk;

    // Independent count of bus_req rising edges.
    always @(negedge clk) begin
        if (dif.bus_req && !prev_req) episodes++;
        prev_req = dif.bus_req;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] dout,
                           input int waits, input logic [31:0] rdata,
                           input bit flush, input bit hold,
                           input logic exp_we, input logic [31:0] exp_din, input int exp_stall);
        int stalls = 0;
        @(negedge clk);
        dif.mem_ren = ren; dif.mem_wen = wen;
        dif.mem_addr = addr; dif.mem_dout = dout; dif.bus_ack = 1'b0;
        #1;
        chk1({tag, ".idle_stall"}, dif.ram_stall, 1'b1);
        chk1({tag, ".idle_req"}, dif.bus_req, 1'b0);
        if (dif.ram_stall) stalls++;
        m_txns++;
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            if (flush && k == 1) begin dif.mem_ren = 1'b0; dif.mem_wen = 1'b0; end
            dif.bus_ack = (k == waits);
            dif.bus_rdata = (k == waits) ? rdata : $urandom();
            #1;
            chk1({tag, ".busy_req"}, dif.bus_req, 1'b1);
            chk1({tag, ".busy_cs"}, dif.ram_cs, 1'b1);
            chk1({tag, ".busy_we"}, dif.bus_we, exp_we);
            chk32({tag, ".busy_addr"}, dif.bus_addr, addr);
            if (exp_we) chk32({tag, ".busy_wdata"}, dif.bus_wdata, dout);
            if (k == 0) chk32({tag, ".busy_din_old"}, dif.mem_din, m_din);
            if (dif.ram_stall) stalls++;
        end
        @(negedge clk);
        dif.bus_ack = 1'b0;
        dif.bus_rdata = $urandom();
        if (!hold || flush) begin dif.mem_ren = 1'b0; dif.mem_wen = 1'b0; end
        #1;
        chk1({tag, ".done_stall"}, dif.ram_stall, 1'b0);
        chk1({tag, ".done_req"}, dif.bus_req, 1'b0);
        chk1({tag, ".done_err"}, dif.bus_err, 1'b0);
        chk32({tag, ".done_din"}, dif.mem_din, exp_din);
        chkn({tag, ".stall_cycles"}, stalls, exp_stall);
        m_din = exp_din;
    endtask

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] dout;
        int          waits;
        logic [31:0] rdata;
        bit          flush;
        logic        exp_we;
        logic [31:0] exp_din;
        int          exp_stall;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n_busy;
        int ep0;
        logic r, w;
        int wt;
        logic [31:0] rd, ad, dd;

        vecs[0] = '{1'b1, 1'b0, 32'h40, 32'h0,        0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D, 2};
        vecs[1] = '{1'b0, 1'b1, 32'h10, 32'h12345678, 3, 32'hDEADBEEF, 1'b0, 1'b1, 32'hCAFEF00D, 5};
        vecs[2] = '{1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 2, 32'h11111111, 1'b1, 1'b1, 32'hCAFEF00D, 4};
        vecs[3] = '{1'b1, 1'b0, 32'h80, 32'h0,        2, 32'h0BADF00D, 1'b1, 1'b0, 32'h0BADF00D, 4};
        vecs[4] = '{1'b1, 1'b0, 32'h0,  32'h0,        1, 32'h00000001, 1'b0, 1'b0, 32'h00000001, 3};

        rst = 1'b1;
        dif.mem_ren = 1'b0; dif.mem_wen = 1'b0;
        dif.mem_addr = '0; dif.mem_dout = '0;
        dif.bus_ack = 1'b0; dif.bus_rdata = '0;
        m_din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk1("rst.req", dif.bus_req, 1'b0);
        chk1("rst.cs", dif.ram_cs, 1'b0);
        chk1("rst.we", dif.bus_we, 1'b0);
        chk32("rst.addr", dif.bus_addr, 32'h0);
        chk32("rst.wdata", dif.bus_wdata, 32'h0);
        chk32("rst.din", dif.mem_din, 32'h0);
        chk1("rst.err", dif.bus_err, 1'b0);
        chk1("rst.stall", dif.ram_stall, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].dout,
                    vecs[i].waits, vecs[i].rdata, vecs[i].flush, 1'b0,
                    vecs[i].exp_we, vecs[i].exp_din, vecs[i].exp_stall);

        // Back-to-back reads; first request held through DONE must not be reissued.
        ep0 = episodes;
        run_txn("b2b0", 1'b1, 1'b0, 32'h0, 32'h0, 0, 32'hAAAA0000, 1'b0, 1'b1, 1'b0, 32'hAAAA0000, 2);
        run_txn("b2b1", 1'b1, 1'b0, 32'h4, 32'h0, 1, 32'hBBBB0004, 1'b0, 1'b0, 1'b0, 32'hBBBB0004, 3);
        @(negedge clk);
        #1;
        chkn("b2b.episodes", episodes - ep0, 2);

        // Ack outside BUSY is ignored.
        @(negedge clk);
        dif.bus_ack = 1'b1; dif.bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dif.bus_ack = 1'b0;
        #1;
        chk32("stray_ack.din", dif.mem_din, m_din);
        chk1("stray_ack.req", dif.bus_req, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            r = (kind != 1);
            w = (kind != 0);
            wt = $urandom_range(0, MAXW);
            rd = $urandom(); ad = $urandom(); dd = $urandom();
            run_txn($sformatf("rnd%0d", i), r, w, ad, dd, wt, rd, 1'b0, 1'b0,
                    w, w ? m_din : rd, wt + 2);
        end

        // Missing ack.
        @(negedge clk);
        dif.mem_ren = 1'b1; dif.mem_wen = 1'b0; dif.mem_addr = 32'h100; dif.bus_ack = 1'b0;
        m_txns++;
`ifdef DMEM_TIMEOUT_EN
        for (int k = 0; k < int'(TB_TIMEOUT); k++) begin
            @(negedge clk);
            #1;
            chk1("to.busy_req", dif.bus_req, 1'b1);
            chk1("to.busy_err", dif.bus_err, 1'b0);
        end
        @(negedge clk);
        dif.mem_ren = 1'b0;
        #1;
        chk1("to.done_req", dif.bus_req, 1'b0);
        chk1("to.done_stall", dif.ram_stall, 1'b0);
        chk1("to.done_err", dif.bus_err, 1'b1);
        chk32("to.done_din", dif.mem_din, 32'h0);
        @(negedge clk);
        #1;
        chk1("to.after_err", dif.bus_err, 1'b0);
        m_din = '0;
`else
        n_busy = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            #1;
            if (dif.ram_stall && dif.bus_req) n_busy++;
        end
        chkn("noack.stall_cycles", n_busy, 120);
        chk1("noack.err", dif.bus_err, 1'b0);
        rst = 1'b1; dif.mem_ren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_din = '0;
`endif

        // Reset in the second BUSY cycle.
        run_txn("pre_rst", 1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 32'h5A5A5A5A, 2);
        @(negedge clk);
        dif.mem_ren = 1'b1; dif.mem_addr = 32'h200;
        m_txns++;
        @(negedge clk);
        #1;
        chk1("rstb.busy1_req", dif.bus_req, 1'b1);
        @(negedge clk);
        rst = 1'b1; dif.mem_ren = 1'b0;
        #1;
        chk1("rstb.req", dif.bus_req, 1'b0);
        chk1("rstb.cs", dif.ram_cs, 1'b0);
        chk1("rstb.stall", dif.ram_stall, 1'b0);
        chk1("rstb.we", dif.bus_we, 1'b0);
        chk32("rstb.addr", dif.bus_addr, 32'h0);
        chk32("rstb.din", dif.mem_din, 32'h0);
        chk1("rstb.err", dif.bus_err, 1'b0);
        m_din = '0;
        @(negedge clk);
        rst = 1'b0; dif.bus_ack = 1'b1; dif.bus_rdata = 32'h77777777;
        @(negedge clk);
        dif.bus_ack = 1'b0;
        #1;
        chk1("rstb.late_ack_req", dif.bus_req, 1'b0);
        chk32("rstb.late_ack_din", dif.mem_din, 32'h0);
        run_txn("post_rst", 1'b1, 1'b0, 32'h300, 32'h0, 1, 32'h13572468, 1'b0, 1'b0, 1'b0, 32'h13572468, 3);

        @(negedge clk);
        #1;
        chkn("total.episodes", episodes, m_txns);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
